// File: rtl/temp_a_packer.sv
// Packs a serial coefficient stream into 48b/50b pair words for the Temp_A dual-bank buffer,
// alternating bank halves and back-pressuring on FIFO occupancy. Optional padding: TEMP_A_PAD_EN.
module temp_a_packer #(
  parameter int DEPTH = 512,
  parameter int CNT_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [24:0] in_data,
  input  logic        in_last,
  input  logic        t_rd_flag,
  input  logic        t_choose,
  output logic        t_wr_flag,
  output logic        t_wr_half,
  output logic [47:0] din_24,
  output logic [49:0] din_25,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_C0   = 3'd0,
    S_C1   = 3'd1,
    S_HOLD = 3'd2,
`ifdef TEMP_A_PAD_EN
    S_PAD  = 3'd4,
`endif
    S_WR   = 3'd3
  } state_t;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  state_t           state_q, state_d;
  logic             half_q, half_d;
  logic [24:0]      c0_q, c0_d;
  logic             last_q, last_d;
  logic             wr_q, wr_d;
  logic             wr_half_q, wr_half_d;
  logic [47:0]      d24_q, d24_d;
  logic [49:0]      d25_q, d25_d;
  logic             fd_q, fd_d;
  logic [CNT_W-1:0] occ48_q [2];
  logic [CNT_W-1:0] occ48_d [2];
  logic [CNT_W-1:0] occ50_q [2];
  logic [CNT_W-1:0] occ50_d [2];
  logic [1:0]       credit_s;
  logic             cur_credit_s;
  logic             rdy_s;
  logic             rsv_s;

  always_comb begin
    for (int h = 0; h < 2; h++) begin
      credit_s[h] = (occ48_q[h] < FULL) && (occ50_q[h] < FULL);
    end
    cur_credit_s = credit_s[half_q];
  end

  // Occupancy: a reservation adds to both FIFOs of its half, reads drain both halves of one width.
  always_comb begin
    for (int h = 0; h < 2; h++) begin
      logic inc_s, dec48_s, dec50_s;
      inc_s   = rsv_s && (half_q == h[0]);
      dec48_s = t_rd_flag && !t_choose && (occ48_q[h] != '0);
      dec50_s = t_rd_flag && t_choose && (occ50_q[h] != '0);
      occ48_d[h] = occ48_q[h];
      occ50_d[h] = occ50_q[h];
      if (inc_s && !dec48_s) begin
        occ48_d[h] = occ48_q[h] + 1'b1;
      end else if (!inc_s && dec48_s) begin
        occ48_d[h] = occ48_q[h] - 1'b1;
      end else begin
        occ48_d[h] = occ48_q[h];
      end
      if (inc_s && !dec50_s) begin
        occ50_d[h] = occ50_q[h] + 1'b1;
      end else if (!inc_s && dec50_s) begin
        occ50_d[h] = occ50_q[h] - 1'b1;
      end else begin
        occ50_d[h] = occ50_q[h];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    c0_d      = c0_q;
    last_d    = last_q;
    wr_d      = 1'b0;
    wr_half_d = wr_half_q;
    d24_d     = d24_q;
    d25_d     = d25_q;
    fd_d      = 1'b0;
    rdy_s     = 1'b0;
    rsv_s     = 1'b0;
    case (state_q)
      S_C0: begin
        rdy_s = 1'b1;
        if (in_valid) begin
          c0_d   = in_data;
          last_d = in_last;
          if (!in_last) begin
            state_d = S_C1;
          end else if (cur_credit_s) begin
            rsv_s     = 1'b1;
            wr_d      = 1'b1;
            wr_half_d = half_q;
            d24_d     = {in_data[23:0], 24'd0};
            d25_d     = {in_data, 25'd0};
            state_d   = S_WR;
          end else begin
            state_d = S_HOLD;
          end
        end else begin
          state_d = S_C0;
        end
      end
      S_C1: begin
        rdy_s = cur_credit_s;
        if (in_valid && cur_credit_s) begin
          rsv_s     = 1'b1;
          wr_d      = 1'b1;
          wr_half_d = half_q;
          d24_d     = {c0_q[23:0], in_data[23:0]};
          d25_d     = {c0_q, in_data};
          last_d    = in_last;
          state_d   = S_WR;
        end else begin
          state_d = S_C1;
        end
      end
      // Lone tail coefficient waiting for room in its half.
      S_HOLD: begin
        if (cur_credit_s) begin
          rsv_s     = 1'b1;
          wr_d      = 1'b1;
          wr_half_d = half_q;
          d24_d     = {c0_q[23:0], 24'd0};
          d25_d     = {c0_q, 25'd0};
          state_d   = S_WR;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_WR: begin
        half_d = ~half_q;
        if (!last_q) begin
          state_d = S_C0;
`ifdef TEMP_A_PAD_EN
        end else if (!half_q) begin
          state_d = S_PAD;
`endif
        end else begin
          fd_d    = 1'b1;
          last_d  = 1'b0;
          state_d = S_C0;
        end
      end
`ifdef TEMP_A_PAD_EN
      // Zero word to half 1 rebalances the banks; it re-enters S_WR, which then ends the frame.
      S_PAD: begin
        if (cur_credit_s) begin
          rsv_s     = 1'b1;
          wr_d      = 1'b1;
          wr_half_d = half_q;
          d24_d     = 48'd0;
          d25_d     = 50'd0;
          state_d   = S_WR;
        end else begin
          state_d = S_PAD;
        end
      end
`endif
      default: begin
        state_d = S_C0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_C0;
      half_q    <= 1'b0;
      c0_q      <= 25'd0;
      last_q    <= 1'b0;
      wr_q      <= 1'b0;
      wr_half_q <= 1'b0;
      d24_q     <= 48'd0;
      d25_q     <= 50'd0;
      fd_q      <= 1'b0;
      for (int h = 0; h < 2; h++) begin
        occ48_q[h] <= '0;
        occ50_q[h] <= '0;
      end
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      c0_q      <= c0_d;
      last_q    <= last_d;
      wr_q      <= wr_d;
      wr_half_q <= wr_half_d;
      d24_q     <= d24_d;
      d25_q     <= d25_d;
      fd_q      <= fd_d;
      for (int h = 0; h < 2; h++) begin
        occ48_q[h] <= occ48_d[h];
        occ50_q[h] <= occ50_d[h];
      end
    end
  end

  assign in_ready   = rst && rdy_s;
  assign t_wr_flag  = wr_q;
  assign t_wr_half  = wr_half_q;
  assign din_24     = d24_q;
  assign din_25     = d25_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_temp_a_packer.sv
// Directed self-checking bench for temp_a_packer; follows TEMP_A_PAD_EN to pick padding expectations.
module tb_temp_a_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_data;
  logic        in_last;
  logic        t_rd_flag;
  logic        t_choose;
  logic        t_wr_flag;
  logic        t_wr_half;
  logic [47:0] din_24;
  logic [49:0] din_25;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  logic [49:0] q25 [$];
  logic [47:0] q24 [$];
  logic        qh  [$];
  int          fd_at [$];

  temp_a_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .t_rd_flag(t_rd_flag), .t_choose(t_choose), .t_wr_flag(t_wr_flag),
    .t_wr_half(t_wr_half), .din_24(din_24), .din_25(din_25), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Write log: every written word and the write count at each frame_done pulse.
  always @(negedge clk) begin
    if (t_wr_flag) begin
      q25.push_back(din_25);
      q24.push_back(din_24);
      qh.push_back(t_wr_half);
    end
    if (frame_done) fd_at.push_back(q25.size());
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [24:0] d, input logic l);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      check_eq("send_timeout", 64'(in_ready), 64'd1);
    end else begin
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic [49:0] w25;
    logic [47:0] w24;
    rst = 1'b0; in_valid = 1'b0; in_data = 25'd0; in_last = 1'b0;
    t_rd_flag = 1'b0; t_choose = 1'b0;
    idle(2);
    check_eq("rst_wr_flag", 64'(t_wr_flag), 64'd0);
    check_eq("rst_wr_half", 64'(t_wr_half), 64'd0);
    check_eq("rst_din_24", 64'(din_24), 64'd0);
    check_eq("rst_din_25", 64'(din_25), 64'd0);
    check_eq("rst_frame_done", 64'(frame_done), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    idle(1);
    check_eq("ready_after_rst", 64'(in_ready), 64'd1);

    // Frame 1,2,3,4
    send(25'd1, 1'b0);
    send(25'd2, 1'b0);
    @(negedge clk);
    check_eq("latency_flag", 64'(t_wr_flag), 64'd1);
    check_eq("latency_half", 64'(t_wr_half), 64'd0);
    send(25'd3, 1'b0);
    send(25'd4, 1'b1);
    idle(5);
    check_eq("f1_count", 64'(q25.size()), 64'd2);
    check_eq("f1_w0_d25", 64'(q25[0]), 64'({25'd1, 25'd2}));
    check_eq("f1_w0_d24", 64'(q24[0]), 64'({24'd1, 24'd2}));
    check_eq("f1_w0_half", 64'(qh[0]), 64'd0);
    check_eq("f1_w1_d25", 64'(q25[1]), 64'({25'd3, 25'd4}));
    check_eq("f1_w1_half", 64'(qh[1]), 64'd1);
    check_eq("f1_fd_count", 64'(fd_at.size()), 64'd1);
    check_eq("f1_fd_after", 64'(fd_at[0]), 64'd2);

    // Full 25-bit value, lane split
    send(25'h1ABCDEF, 1'b0);
    send(25'd1, 1'b0);
    send(25'd8, 1'b0);
    send(25'd9, 1'b1);
    idle(5);
    w25 = q25[2];
    w24 = q24[2];
    check_eq("wide_d25_hi", 64'(w25[49:25]), 64'h1ABCDEF);
    check_eq("wide_d24_hi", 64'(w24[47:24]), 64'hABCDEF);
    check_eq("wide_half", 64'(qh[2]), 64'd0);
    check_eq("f2_w1", 64'(q25[3]), 64'({25'd8, 25'd9}));
    check_eq("f2_w1_half", 64'(qh[3]), 64'd1);

    // Odd frame 5,6,7 -> zero-filled tail
    send(25'd5, 1'b0);
    send(25'd6, 1'b0);
    send(25'd7, 1'b1);
    idle(5);
    check_eq("odd_w0", 64'(q25[4]), 64'({25'd5, 25'd6}));
    check_eq("odd_w0_half", 64'(qh[4]), 64'd0);
    check_eq("odd_tail_d25", 64'(q25[5]), 64'({25'd7, 25'd0}));
    check_eq("odd_tail_d24", 64'(q24[5]), 64'({24'd7, 24'd0}));
    check_eq("odd_tail_half", 64'(qh[5]), 64'd1);
    check_eq("odd_fd_after", 64'(fd_at[2]), 64'd6);

    // Two-coefficient frame ending on half 0
    send(25'd10, 1'b0);
    send(25'd11, 1'b1);
    idle(8);
    check_eq("short_w0", 64'(q25[6]), 64'({25'd10, 25'd11}));
    check_eq("short_w0_half", 64'(qh[6]), 64'd0);
    check_eq("short_fd_count", 64'(fd_at.size()), 64'd4);
`ifdef TEMP_A_PAD_EN
    check_eq("pad_count", 64'(q25.size()), 64'd8);
    check_eq("pad_word", 64'(q25[7]), 64'd0);
    check_eq("pad_half", 64'(qh[7]), 64'd1);
    check_eq("pad_fd_after", 64'(fd_at[3]), 64'd8);
`else
    check_eq("nopad_count", 64'(q25.size()), 64'd7);
    check_eq("nopad_fd_after", 64'(fd_at[3]), 64'd7);
`endif

    // Reset while holding c0
    n = q25.size();
    send(25'd12, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check_eq("midrst_wr_flag", 64'(t_wr_flag), 64'd0);
    check_eq("midrst_din_25", 64'(din_25), 64'd0);
    rst = 1'b1;
    idle(3);
    check_eq("midrst_no_write", 64'(q25.size()), 64'(n));
    send(25'd13, 1'b0);
    send(25'd14, 1'b0);
    idle(4);
    check_eq("midrst_next", 64'(q25[n]), 64'({25'd13, 25'd14}));
    check_eq("midrst_next_half", 64'(qh[n]), 64'd0);

    // Fill both halves to DEPTH, then drain one word of each width
    do_reset();
    n = q25.size();
    for (int i = 0; i < 2048; i++) send(25'(i), 1'b0);
    idle(5);
    check_eq("fill_count", 64'(q25.size() - n), 64'd1024);
    send(25'h55, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 25'h66;
    check_eq("stall_full", 64'(in_ready), 64'd0);
    t_rd_flag = 1'b1;
    t_choose  = 1'b0;
    @(negedge clk);
    t_rd_flag = 1'b0;
    @(negedge clk);
    check_eq("stall_48_only", 64'(in_ready), 64'd0);
    t_rd_flag = 1'b1;
    t_choose  = 1'b1;
    @(negedge clk);
    t_rd_flag = 1'b0;
    t_choose  = 1'b0;
    check_eq("resume", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    idle(4);
    check_eq("resume_count", 64'(q25.size() - n), 64'd1025);
    check_eq("resume_word", 64'(q25[q25.size() - 1]), 64'({25'h55, 25'h66}));
    check_eq("resume_half", 64'(qh[qh.size() - 1]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
